// File: rtl/int_ctrl_vec.sv
// int_ctrl_vec: vectored interrupt controller.
// Collects level requests into a pending register, arbitrates eligible lines
// by fixed priority (lowest index wins), walks a CSR save sequence
// (mepc, mcause, mstatus), then redirects fetch to the handler. Also performs
// the mret mstatus restore and redirect back to mepc. All outputs are
// registered and decoded from the next state, so they line up with the
// current state and clear asynchronously on reset.

module int_ctrl_vec #(
   parameter int          INT_NUM      = 8,
   parameter int          DATA_W       = 16,
   parameter int          ADDR_W       = 16,
   parameter int          VECTORED     = 1,
   parameter int          VEC_STRIDE   = 4,
   parameter int          CAUSE_BASE   = 16,
   parameter int unsigned MSTATUS_ADDR = 32'h0000_0300,
   parameter int unsigned MEPC_ADDR    = 32'h0000_0341,
   parameter int unsigned MCAUSE_ADDR  = 32'h0000_0342
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INT_NUM-1:0] int_req,
   input  logic [INT_NUM-1:0] csr_mie,
   input  logic               global_int_en,
   input  logic               mret_flag,
   input  logic [ADDR_W-1:0]  inst_addr,
   input  logic               jump_flag,
   input  logic [ADDR_W-1:0]  jump_addr,
   input  logic [DATA_W-1:0]  csr_mtvec,
   input  logic [DATA_W-1:0]  csr_mepc,
   input  logic [DATA_W-1:0]  csr_mstatus,
   output logic               hold_flag_int,
   output logic               csr_we,
   output logic [ADDR_W-1:0]  csr_waddr,
   output logic [DATA_W-1:0]  csr_wdata,
   output logic               int_assert,
   output logic [ADDR_W-1:0]  int_addr,
   output logic [INT_NUM-1:0] int_ack
);

   localparam int IDX_W = (INT_NUM > 32'sd1) ? $clog2(INT_NUM) : 1;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      SAVE_EPC    = 3'd1,
      SAVE_CAUSE  = 3'd2,
      SAVE_STATUS = 3'd3,
      JUMP        = 3'd4,
      MRET_ST     = 3'd5,
      MRET_JMP    = 3'd6
   } state_t;

   // mstatus on trap entry: MPIE takes the old MIE, MIE is cleared.
   function automatic logic [DATA_W-1:0] trap_status(input logic [DATA_W-1:0] s);
      logic [DATA_W-1:0] r;
      r    = s;
      r[7] = s[3];
      r[3] = 1'b0;
      return r;
   endfunction

   // mstatus on mret: MIE takes MPIE back, MPIE is set.
   function automatic logic [DATA_W-1:0] mret_status(input logic [DATA_W-1:0] s);
      logic [DATA_W-1:0] r;
      r    = s;
      r[3] = s[7];
      r[7] = 1'b1;
      return r;
   endfunction

   // mcause value: interrupt flag in the MSB, CAUSE_BASE + idx below it.
   function automatic logic [DATA_W-1:0] cause_word(input logic [IDX_W-1:0] idx);
      logic [DATA_W-1:0] r;
      r = DATA_W'(CAUSE_BASE) + DATA_W'(idx);
      r[DATA_W-1] = 1'b1;
      return r;
   endfunction

   // Handler address, wrapping modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] vec_target(input logic [DATA_W-1:0] base,
                                                    input logic [IDX_W-1:0]  idx);
      logic [31:0] off;
      off = (VECTORED != 32'sd0) ? (32'(idx) * 32'(VEC_STRIDE)) : 32'd0;
      return ADDR_W'(32'(base) + off);
   endfunction

   // One-hot decode of a line index.
   function automatic logic [INT_NUM-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [INT_NUM-1:0] r;
      for (int i = 0; i < INT_NUM; i++) begin
         r[i] = (IDX_W'(i) == idx);
      end
      return r;
   endfunction

   state_t              state_q, state_d;
   logic [INT_NUM-1:0]  pending_q, pending_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [ADDR_W-1:0]   epc_q, epc_d;
   logic [DATA_W-1:0]   status_q, status_d;

   logic                hold_q, hold_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                assert_q, assert_d;
   logic [ADDR_W-1:0]   iaddr_q, iaddr_d;
   logic [INT_NUM-1:0]  ack_q, ack_d;

   logic [INT_NUM-1:0]  eligible_s;
   logic [IDX_W-1:0]    win_idx_s;
   logic                accept_s;

   // Fixed-priority arbitration over enabled pending lines, lowest index wins.
   always_comb begin
      eligible_s = pending_q & csr_mie;
      win_idx_s  = {IDX_W{1'b0}};
      for (int i = INT_NUM - 1; i >= 0; i--) begin
         if (eligible_s[i]) begin
            win_idx_s = IDX_W'(i);
         end else begin
            win_idx_s = win_idx_s;
         end
      end
      accept_s = (state_q == IDLE) && global_int_en && (|eligible_s) && !mret_flag;
   end

   // Next-state logic plus pending/context capture at acceptance.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q | int_req;
      idx_d     = idx_q;
      epc_d     = epc_q;
      status_d  = status_q;
      case (state_q)
         IDLE: begin
            if (mret_flag) begin
               state_d = MRET_ST;
            end else if (accept_s) begin
               state_d   = SAVE_EPC;
               idx_d     = win_idx_s;
               epc_d     = jump_flag ? jump_addr : inst_addr;
               status_d  = csr_mstatus;
               pending_d = (pending_q | int_req) & ~onehot(win_idx_s);
            end else begin
               state_d = IDLE;
            end
         end
         SAVE_EPC:    state_d = SAVE_CAUSE;
         SAVE_CAUSE:  state_d = SAVE_STATUS;
         SAVE_STATUS: state_d = JUMP;
         JUMP:        state_d = IDLE;
         MRET_ST:     state_d = MRET_JMP;
         MRET_JMP:    state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   // Output decode from the next state so registered outputs match the state.
   always_comb begin
      hold_d   = (state_d != IDLE);
      we_d     = 1'b0;
      waddr_d  = {ADDR_W{1'b0}};
      wdata_d  = {DATA_W{1'b0}};
      assert_d = 1'b0;
      iaddr_d  = {ADDR_W{1'b0}};
      ack_d    = {INT_NUM{1'b0}};
      case (state_d)
         IDLE: begin
            hold_d = 1'b0;
         end
         SAVE_EPC: begin
            we_d    = 1'b1;
            waddr_d = ADDR_W'(MEPC_ADDR);
            wdata_d = DATA_W'(epc_d);
            ack_d   = onehot(idx_d);
         end
         SAVE_CAUSE: begin
            we_d    = 1'b1;
            waddr_d = ADDR_W'(MCAUSE_ADDR);
            wdata_d = cause_word(idx_d);
         end
         SAVE_STATUS: begin
            we_d    = 1'b1;
            waddr_d = ADDR_W'(MSTATUS_ADDR);
            wdata_d = trap_status(status_d);
         end
         JUMP: begin
            assert_d = 1'b1;
            iaddr_d  = vec_target(csr_mtvec, idx_d);
         end
         MRET_ST: begin
            we_d    = 1'b1;
            waddr_d = ADDR_W'(MSTATUS_ADDR);
            wdata_d = mret_status(csr_mstatus);
         end
         MRET_JMP: begin
            assert_d = 1'b1;
            iaddr_d  = ADDR_W'(csr_mepc);
         end
         default: begin
            hold_d = 1'b0;
         end
      endcase
   end

   // State, context and output registers; reset aborts any sequence at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= {INT_NUM{1'b0}};
         idx_q     <= {IDX_W{1'b0}};
         epc_q     <= {ADDR_W{1'b0}};
         status_q  <= {DATA_W{1'b0}};
         hold_q    <= 1'b0;
         we_q      <= 1'b0;
         waddr_q   <= {ADDR_W{1'b0}};
         wdata_q   <= {DATA_W{1'b0}};
         assert_q  <= 1'b0;
         iaddr_q   <= {ADDR_W{1'b0}};
         ack_q     <= {INT_NUM{1'b0}};
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         idx_q     <= idx_d;
         epc_q     <= epc_d;
         status_q  <= status_d;
         hold_q    <= hold_d;
         we_q      <= we_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         assert_q  <= assert_d;
         iaddr_q   <= iaddr_d;
         ack_q     <= ack_d;
      end
   end

   assign hold_flag_int = hold_q;
   assign csr_we        = we_q;
   assign csr_waddr     = waddr_q;
   assign csr_wdata     = wdata_q;
   assign int_assert    = assert_q;
   assign int_addr      = iaddr_q;
   assign int_ack       = ack_q;

endmodule

// File: tb/tb_int_ctrl_vec.sv
// Testbench for int_ctrl_vec: directed scenarios plus randomized traffic.
// A cycle-level reference model pushes expected CSR writes, redirects and
// acknowledges into queues; a monitor pops and compares when the DUT emits them.

module tb_int_ctrl_vec;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  int_req = 8'h00;
   logic [7:0]  csr_mie = 8'h00;
   logic        global_int_en = 1'b0;
   logic        mret_flag = 1'b0;
   logic [15:0] inst_addr = 16'h0000;
   logic        jump_flag = 1'b0;
   logic [15:0] jump_addr = 16'h0000;
   logic [15:0] csr_mtvec = 16'h0000;
   logic [15:0] csr_mepc = 16'h0000;
   logic [15:0] csr_mstatus = 16'h0000;
   logic        hold_flag_int;
   logic        csr_we;
   logic [15:0] csr_waddr;
   logic [15:0] csr_wdata;
   logic        int_assert;
   logic [15:0] int_addr;
   logic [7:0]  int_ack;

   int_ctrl_vec dut (
      .clk(clk), .rst(rst), .int_req(int_req), .csr_mie(csr_mie),
      .global_int_en(global_int_en), .mret_flag(mret_flag),
      .inst_addr(inst_addr), .jump_flag(jump_flag), .jump_addr(jump_addr),
      .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .csr_mstatus(csr_mstatus),
      .hold_flag_int(hold_flag_int), .csr_we(csr_we), .csr_waddr(csr_waddr),
      .csr_wdata(csr_wdata), .int_assert(int_assert), .int_addr(int_addr),
      .int_ack(int_ack)
   );

   always #5 clk = ~clk;

   typedef struct { logic [15:0] a; logic [15:0] d; } wr_t;
   wr_t         wq[$];
   logic [15:0] jq[$];
   logic [7:0]  aq[$];

   int          vectors = 0;
   int          miscompares = 0;
   logic [7:0]  m_pend = 8'h00;
   int          m_busy = 0;
   logic        exp_hold = 1'b0;

   logic [15:0] last_mepc = 16'h0, last_mcause = 16'h0, last_mstat = 16'h0;
   logic [15:0] last_jaddr = 16'h0;
   logic [7:0]  last_ack = 8'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference rules written as plain arithmetic on mstatus bits 3 (MIE) and 7 (MPIE).
   function automatic logic [15:0] ref_trap_status(input logic [15:0] s);
      return (s & ~16'h0088) | ((s & 16'h0008) << 4);
   endfunction

   function automatic logic [15:0] ref_mret_status(input logic [15:0] s);
      return (s & ~16'h0088) | 16'h0080 | ((s & 16'h0080) >> 4);
   endfunction

   function automatic int lowest(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Model of what the coming clock edge does, given the inputs now applied.
   task automatic model_step();
      logic [7:0]  elig;
      logic [15:0] epc;
      int          w;
      wr_t         e;
      if (m_busy > 0) begin
         m_busy--;
         m_pend = m_pend | int_req;
      end else begin
         elig = m_pend & csr_mie;
         if (mret_flag) begin
            e.a = 16'h0300; e.d = ref_mret_status(csr_mstatus); wq.push_back(e);
            jq.push_back(csr_mepc);
            m_busy = 2;
            m_pend = m_pend | int_req;
         end else if (global_int_en && elig != 8'h00) begin
            w   = lowest(elig);
            epc = jump_flag ? jump_addr : inst_addr;
            aq.push_back(8'(1 << w));
            e.a = 16'h0341; e.d = epc;                         wq.push_back(e);
            e.a = 16'h0342; e.d = 16'h8000 | 16'(16 + w);      wq.push_back(e);
            e.a = 16'h0300; e.d = ref_trap_status(csr_mstatus); wq.push_back(e);
            jq.push_back(16'(int'(csr_mtvec) + w * 4));
            m_busy = 4;
            m_pend = (m_pend | int_req) & ~(8'(1 << w));
         end else begin
            m_pend = m_pend | int_req;
         end
      end
      exp_hold = (m_busy > 0);
   endtask

   task automatic model_reset();
      m_pend = 8'h00; m_busy = 0; exp_hold = 1'b0;
      wq.delete(); jq.delete(); aq.delete();
   endtask

   // Apply one cycle of stimulus (called at a negedge), step the model, wait a cycle.
   task automatic drive(input logic [7:0] req, input logic mret, input logic jf, input bit rnd);
      int_req   = req;
      mret_flag = mret;
      jump_flag = jf;
      if (rnd) begin
         inst_addr     = 16'($urandom);
         jump_addr     = 16'($urandom);
         global_int_en = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 7) == 0) csr_mie = 8'($urandom);
         if (m_busy == 0) begin
            csr_mtvec   = 16'($urandom);
            csr_mepc    = 16'($urandom);
            csr_mstatus = 16'($urandom);
         end
      end
      model_step();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   // Monitor: checks hold every cycle and pops expectations on each DUT output.
   initial begin
      wr_t e;
      forever begin
         @(posedge clk);
         #1;
         check("hold_flag_int", 32'(hold_flag_int), 32'(exp_hold));
         if (csr_we) begin
            if (wq.size() == 0) begin
               check("unexpected_csr_write", {csr_waddr, csr_wdata}, 32'h0);
            end else begin
               e = wq.pop_front();
               check("csr_waddr", 32'(csr_waddr), 32'(e.a));
               check("csr_wdata", 32'(csr_wdata), 32'(e.d));
            end
            if (csr_waddr == 16'h0341) last_mepc = csr_wdata;
            if (csr_waddr == 16'h0342) last_mcause = csr_wdata;
            if (csr_waddr == 16'h0300) last_mstat = csr_wdata;
         end
         if (int_assert) begin
            if (jq.size() == 0) check("unexpected_int_assert", 32'(int_addr), 32'hFFFF_FFFF);
            else check("int_addr", 32'(int_addr), 32'(jq.pop_front()));
            last_jaddr = int_addr;
         end
         if (int_ack != 8'h00) begin
            if (aq.size() == 0) check("unexpected_int_ack", 32'(int_ack), 32'h0);
            else check("int_ack", 32'(int_ack), 32'(aq.pop_front()));
            last_ack = int_ack;
         end
      end
   end

   initial begin
      // Reset then idle.
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_hold", 32'(hold_flag_int), 32'h0);
      check("reset_we", 32'(csr_we), 32'h0);
      check("reset_assert", 32'(int_assert), 32'h0);
      check("reset_ack", 32'(int_ack), 32'h0);
      check("reset_addr", {csr_waddr, int_addr}, 32'h0);
      rst = 1'b0;
      idle(3);

      // Single vectored interrupt on line 2.
      csr_mtvec = 16'h0100; csr_mie = 8'hFF; global_int_en = 1'b1;
      csr_mstatus = 16'h0008; inst_addr = 16'h0040;
      drive(8'h04, 1'b0, 1'b0, 1'b0);
      idle(8);
      check("single_mepc", 32'(last_mepc), 32'h0040);
      check("single_mcause", 32'(last_mcause), 32'h8012);
      check("single_mstatus", 32'(last_mstat), 32'h0080);
      check("single_int_addr", 32'(last_jaddr), 32'h0108);
      check("single_int_ack", 32'(last_ack), 32'h04);

      // Priority and mask: line 1 masked, line 3 taken.
      csr_mstatus = 16'h0008; csr_mie = 8'hFD;
      drive(8'h0A, 1'b0, 1'b0, 1'b0);
      idle(8);
      check("prio_int_addr", 32'(last_jaddr), 32'h010C);
      check("prio_int_ack", 32'(last_ack), 32'h08);

      // mret restore; line 1 still masked afterwards.
      csr_mepc = 16'h0040; csr_mstatus = 16'h0080;
      drive(8'h00, 1'b1, 1'b0, 1'b0);
      idle(6);
      check("mret_mstatus", 32'(last_mstat), 32'h0088);
      check("mret_int_addr", 32'(last_jaddr), 32'h0040);
      csr_mie = 8'hFF; csr_mstatus = 16'h0008;
      idle(8);
      check("unmask_int_addr", 32'(last_jaddr), 32'h0104);

      // Jump collision on the acceptance edge.
      drive(8'h01, 1'b0, 1'b0, 1'b0);
      jump_addr = 16'h0200;
      drive(8'h00, 1'b0, 1'b1, 1'b0);
      idle(8);
      check("jump_mepc", 32'(last_mepc), 32'h0200);

      // mret and eligible request in the same cycle: mret first.
      global_int_en = 1'b0;
      drive(8'h02, 1'b0, 1'b0, 1'b0);
      global_int_en = 1'b1; csr_mepc = 16'h0080; csr_mstatus = 16'h0080;
      drive(8'h00, 1'b1, 1'b0, 1'b0);
      check("conflict_mret_first", 32'(csr_waddr), 32'h0300);
      idle(10);
      check("conflict_int_addr", 32'(last_jaddr), 32'h0104);

      // Reset asserted in SAVE_CAUSE, with a request pending on line 7.
      csr_mstatus = 16'h0008;
      drive(8'h01, 1'b0, 1'b0, 1'b0);
      drive(8'h00, 1'b0, 1'b0, 1'b0);
      drive(8'h80, 1'b0, 1'b0, 1'b0);
      check("pre_reset_we", 32'(csr_we), 32'h1);
      check("pre_reset_waddr", 32'(csr_waddr), 32'h0342);
      #2 rst = 1'b1;
      model_reset();
      #1;
      check("async_reset_we", 32'(csr_we), 32'h0);
      check("async_reset_hold", 32'(hold_flag_int), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      idle(6);

      // Randomized traffic.
      for (int k = 0; k < 600; k++) begin
         drive(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
               ($urandom_range(0, 15) == 0), 1'($urandom), 1'b1);
      end
      global_int_en = 1'b0;
      idle(10);

      check("leftover_writes", 32'(wq.size()), 32'h0);
      check("leftover_jumps", 32'(jq.size()), 32'h0);
      check("leftover_acks", 32'(aq.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
